// File: rtl/sc_div_sng.sv
// Dual-channel stochastic number generator feeding the stochastic divider.
// Three de Bruijn 6-bit LFSRs give exact one-counts over every 64-bit window.
module sc_div_sng #(
  parameter int unsigned LEN    = 64,
  parameter logic [5:0]  SEED_A = 6'h01,
  parameter logic [5:0]  SEED_B = 6'h15,
  parameter logic [5:0]  SEED_R = 6'h2A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  input  logic [5:0] dividend_bin,
  input  logic [5:0] divisor_bin,
  output logic       dividend,
  output logic       divisor,
  output logic [5:0] randNum,
  output logic       valid,
  output logic       first,
  output logic       last,
  output logic       busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] LEN16 = 16'(LEN);

  state_t      state_q, state_d;
  logic [5:0]  opa_q, opa_d, opb_q, opb_d;
  logic [5:0]  lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d, lfsr_r_q, lfsr_r_d;
  logic [15:0] cnt_q, cnt_d;
  logic        first_pend_q, first_pend_d;
  logic        dividend_q, dividend_d, divisor_q, divisor_d;
  logic [5:0]  rand_q, rand_d;
  logic        valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic        busy_q, busy_d;

  // The all-zero-low-bits term inserts 6'h00 into the sequence (period 64).
  function automatic logic [5:0] lfsr_step(input logic [5:0] s);
    return {s[4:0], s[5] ^ s[4] ^ (s[4:0] == 5'b0)};
  endfunction

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    lfsr_a_d     = lfsr_a_q;
    lfsr_b_d     = lfsr_b_q;
    lfsr_r_d     = lfsr_r_q;
    cnt_d        = cnt_q;
    first_pend_d = first_pend_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    rand_d       = rand_q;
    valid_d      = 1'b0;
    first_d      = 1'b0;
    last_d       = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        dividend_d = 1'b0;
        divisor_d  = 1'b0;
        busy_d     = start;
        if (start) begin
          state_d      = RUN;
          opa_d        = dividend_bin;
          opb_d        = divisor_bin;
          lfsr_a_d     = SEED_A;
          lfsr_b_d     = SEED_B;
          lfsr_r_d     = SEED_R;
          cnt_d        = LEN16;
          first_pend_d = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (!hold) begin
          dividend_d   = (opa_q > lfsr_a_q);
          divisor_d    = (opb_q > lfsr_b_q);
          rand_d       = lfsr_r_q;
          valid_d      = 1'b1;
          first_d      = first_pend_q;
          first_pend_d = 1'b0;
          last_d       = (cnt_q == 16'd1);
          lfsr_a_d     = lfsr_step(lfsr_a_q);
          lfsr_b_d     = lfsr_step(lfsr_b_q);
          lfsr_r_d     = lfsr_step(lfsr_r_q);
          cnt_d        = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      lfsr_a_q     <= SEED_A;
      lfsr_b_q     <= SEED_B;
      lfsr_r_q     <= SEED_R;
      cnt_q        <= '0;
      first_pend_q <= 1'b0;
      dividend_q   <= 1'b0;
      divisor_q    <= 1'b0;
      rand_q       <= '0;
      valid_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      lfsr_a_q     <= lfsr_a_d;
      lfsr_b_q     <= lfsr_b_d;
      lfsr_r_q     <= lfsr_r_d;
      cnt_q        <= cnt_d;
      first_pend_q <= first_pend_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      rand_q       <= rand_d;
      valid_q      <= valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  assign dividend = dividend_q;
  assign divisor  = divisor_q;
  assign randNum  = rand_q;
  assign valid    = valid_q;
  assign first    = first_q;
  assign last     = last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sc_div_sng.sv
// Scoreboard bench for sc_div_sng: a reference LFSR model predicts every bit of each run.
module tb_sc_div_sng;

  localparam int unsigned LEN    = 64;
  localparam logic [5:0]  SEED_A = 6'h01;
  localparam logic [5:0]  SEED_B = 6'h15;
  localparam logic [5:0]  SEED_R = 6'h2A;

  typedef struct packed {
    logic       dd;
    logic       ds;
    logic [5:0] rn;
    logic       fi;
    logic       la;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] dividend_bin = '0;
  logic [5:0] divisor_bin = '0;
  logic       dividend, divisor, valid, first, last, busy;
  logic [5:0] randNum;

  logic       start1 = 1'b0;
  logic       hold1 = 1'b0;
  logic       dividend1, divisor1, valid1, first1, last1, busy1;
  logic [5:0] randNum1;

  int   n_vec = 0;
  int   n_err = 0;
  int   ones_a, ones_b, nvalid;
  logic [63:0] seen;
  exp_t sb[$];
  exp_t last_exp;
  int   kl;

  always #5 clk = ~clk;

  sc_div_sng #(.LEN(LEN), .SEED_A(SEED_A), .SEED_B(SEED_B), .SEED_R(SEED_R)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .dividend_bin(dividend_bin), .divisor_bin(divisor_bin),
    .dividend(dividend), .divisor(divisor), .randNum(randNum),
    .valid(valid), .first(first), .last(last), .busy(busy)
  );

  sc_div_sng #(.LEN(1), .SEED_A(SEED_A), .SEED_B(SEED_B), .SEED_R(SEED_R)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .hold(hold1),
    .dividend_bin(dividend_bin), .divisor_bin(divisor_bin),
    .dividend(dividend1), .divisor(divisor1), .randNum(randNum1),
    .valid(valid1), .first(first1), .last(last1), .busy(busy1)
  );

  function automatic logic [5:0] model_step(input logic [5:0] s);
    logic fb;
    fb = s[5] ^ s[4];
    if (s[4:0] == 5'd0) fb = ~fb;
    return {s[4:0], fb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      nvalid++;
      ones_a += int'(dividend);
      ones_b += int'(divisor);
      seen[randNum] = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        last_exp = sb.pop_front();
        chk("stream", {22'd0, dividend, divisor, randNum, first, last}, {22'd0, last_exp});
      end
    end
  end

  task automatic begin_run(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] la, lb, lr;
    dividend_bin = a;
    divisor_bin  = b;
    hold   = 1'b0;
    start  = 1'b1;
    ones_a = 0;
    ones_b = 0;
    nvalid = 0;
    seen   = '0;
    la = SEED_A; lb = SEED_B; lr = SEED_R;
    for (int unsigned i = 0; i < LEN; i++) begin
      sb.push_back('{dd: (a > la), ds: (b > lb), rn: lr, fi: (i == 0), la: (i == LEN - 1)});
      la = model_step(la);
      lb = model_step(lb);
      lr = model_step(lr);
    end
  endtask

  task automatic wait_run(input int hold_at, input int poke_at, output int klast);
    tick();
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("valid_at_accept", 32'(valid), 32'd0);
    klast = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (hold_at > 0 && k > hold_at && k <= hold_at + 5) begin
        chk("hold_valid", 32'(valid), 32'd0);
        chk("hold_frozen", {24'd0, dividend, divisor, randNum},
            {24'd0, last_exp.dd, last_exp.ds, last_exp.rn});
      end
      if (hold_at > 0 && k == hold_at) hold = 1'b1;
      if (hold_at > 0 && k == hold_at + 5) hold = 1'b0;
      if (poke_at > 0 && k == poke_at) begin
        start = 1'b1;
        dividend_bin = 6'd1;
        divisor_bin  = 6'd1;
      end
      if (poke_at > 0 && k == poke_at + 1) start = 1'b0;
      if (last) begin
        klast = k;
        break;
      end
    end
    if (klast < 0) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic end_checks(input int ea, input int eb, input int kexp, input int klast);
    chk("ones_dividend", 32'(ones_a), 32'(ea));
    chk("ones_divisor", 32'(ones_b), 32'(eb));
    chk("valid_count", 32'(nvalid), 32'(LEN));
    chk("run_length", 32'(klast), 32'(kexp));
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    ones_a = 0; ones_b = 0; nvalid = 0; seen = '0; last_exp = '0;

    // Reset held three cycles, then idle with no start.
    repeat (3) begin
      tick();
      chk("reset_outputs", {20'd0, dividend, divisor, randNum, valid, first, last, busy}, 32'd0);
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      chk("idle_outputs", {20'd0, dividend, divisor, randNum, valid, first, last, busy}, 32'd0);
    end

    // Exact counts 40/20.
    begin_run(6'd40, 6'd20);
    wait_run(0, 0, kl);
    end_checks(40, 20, 64, kl);
    tick();
    chk("busy_fall", 32'(busy), 32'd0);
    chk("idle_streams", {29'd0, valid, dividend, divisor}, 32'd0);

    // Boundary operands and randNum coverage.
    begin_run(6'd0, 6'd63);
    wait_run(0, 0, kl);
    end_checks(0, 63, 64, kl);
    chk("rand_cover_lo", seen[31:0], 32'hFFFF_FFFF);
    chk("rand_cover_hi", seen[63:32], 32'hFFFF_FFFF);
    tick();

    // Five hold cycles after bit 20.
    begin_run(6'd40, 6'd20);
    wait_run(20, 0, kl);
    end_checks(40, 20, 69, kl);
    tick();

    // Start/operand poke during RUN, then back-to-back start right after last.
    begin_run(6'd40, 6'd20);
    wait_run(0, 10, kl);
    end_checks(40, 20, 64, kl);
    begin_run(6'd40, 6'd20);
    wait_run(0, 0, kl);
    end_checks(40, 20, 64, kl);
    tick();

    // Reset at bit 30, then a fresh run must match the model from the start.
    begin_run(6'd40, 6'd20);
    tick();
    start = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("async_reset", {20'd0, dividend, divisor, randNum, valid, first, last, busy}, 32'd0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_idle", {20'd0, dividend, divisor, randNum, valid, first, last, busy}, 32'd0);
    begin_run(6'd40, 6'd20);
    wait_run(0, 0, kl);
    end_checks(40, 20, 64, kl);
    tick();

    // LEN=1 instance: one bit with first and last together.
    dividend_bin = 6'd40;
    divisor_bin  = 6'd20;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("len1_accept", {30'd0, valid1, busy1}, 32'd1);
    tick();
    chk("len1_bit", {20'd0, dividend1, divisor1, randNum1, valid1, first1, last1, busy1},
        {20'd0, 1'b1, 1'b0, SEED_R, 1'b1, 1'b1, 1'b1, 1'b1});
    tick();
    chk("len1_done", {30'd0, valid1, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc_div_sng.md
# sc_div_sng

Dual-channel stochastic number generator for the stochastic divider stage. It converts two 6-bit unsigned binary operands into unipolar bitstreams `dividend` and `divisor`, plus an independent 6-bit random word `randNum` for the divider's comparator. Each stream runs for a programmable length. It uses three de Bruijn-extended 6-bit LFSRs, so every 64-cycle window has exactly `bin` ones per channel. The block sits directly upstream of the divider and drives its `randNum`, `dividend` and `divisor` inputs bit-for-bit.

## Interface
- `LEN`, 64: stream length in bit-cycles per run, 1..65535.
- `SEED_A`, 6'h01: reload value of LFSR A (dividend channel).
- `SEED_B`, 6'h15: reload value of LFSR B (divisor channel).
- `SEED_R`, 6'h2A: reload value of LFSR R (randNum channel).
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `hold`  in  1  stall; freezes LFSRs, counter and outputs; forces `valid` low.
- `dividend_bin`  in  6  dividend operand, value/64.
- `divisor_bin`  in  6  divisor operand, value/64.
- `dividend`  out  1  dividend bitstream bit.
- `divisor`  out  1  divisor bitstream bit.
- `randNum`  out  6  random word for the downstream comparator.
- `valid`  out  1  the stream outputs carry a live bit this cycle.
- `first`  out  1  marks the first valid bit of a run.
- `last`  out  1  marks the final valid bit of a run.
- `busy`  out  1  high from the `start` acceptance edge until the `last` bit's cycle ends.

## Operation
- **FSM states:** IDLE and RUN.
- **IDLE → RUN:** on an edge where `start`=1.
  - Latch `dividend_bin` into opA and `divisor_bin` into opB.
  - Load LFSRs with `SEED_A`, `SEED_B` and `SEED_R`.
  - Set cnt=`LEN` (16 bits) and set the first-pending flag.
- **RUN, edge with `hold`=0:**
  - Register `dividend`=(opA > lfsrA) and `divisor`=(opB > lfsrB). Comparisons are strict and unsigned.
  - Register `randNum`=lfsrR and `valid`=1.
  - Register `first`=first-pending, then clear first-pending.
  - Register `last`=(cnt==1).
  - Step all three LFSRs and decrement cnt.
  - If cnt==1, go to IDLE.
- **RUN, edge with `hold`=1:** no state change. `valid`, `first` and `last` register 0. `dividend`, `divisor` and `randNum` hold their values.
- **LFSR step (each channel):** s ← {s[4:0], s[5]^s[4]^(s[4:0]==5'b0)}. Period is exactly 64 and includes 6'h00. Every seed, including 0, is legal.
- **Stream exactness:** across 64 consecutive non-hold RUN cycles, the count of ones on `dividend` equals opA exactly; likewise `divisor` equals opB.
- **Operand range:** operand 0 gives an all-zero stream. Operand 63 gives 63 ones per 64.
- **`start` during RUN:** ignored; operands are not re-latched.
- **Input changes:** operand input changes during RUN have no effect.
- **`valid`=0:** `dividend` and `divisor` are registered 0, except under hold, where they keep their last values.
- **IDLE outputs:** `valid`, `first`, `last` and `busy` are 0.
- **`LEN`=1:** a single valid bit with `first`=`last`=1.
- **Reset:** at any time, including mid-run, it forces:
  - State IDLE, cnt=0, all outputs 0.
  - LFSRs loaded with their seeds.
  - No partial run resumes.

## Timing
- **Run length:** `start` sampled at edge E0. The first valid bit appears after E1, and `last` appears after E`LEN` when there are no holds. Each hold cycle adds one cycle.
- **Outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **`busy`:** rises after E0 and falls after the edge following the `last` cycle. A new `start` is accepted at that same edge; there are no dead cycles between back-to-back runs.
- **Reset values:** `dividend`=0, `divisor`=0, `randNum`=0, `valid`=0, `first`=0, `last`=0, `busy`=0.
- **Downstream divider:** it consumes `dividend`, `divisor` and `randNum` in the same cycle. `randNum` is uncorrelated with both streams because it uses an independent LFSR and seed.

## Test plan
- **Reset:** assert `rst` for 3 cycles, then release with no `start` → all outputs 0 and `busy`=0 indefinitely.
- **Exact counts:** `LEN`=64, `dividend_bin`=6'd40, `divisor_bin`=6'd20, pulse `start` → exactly 64 `valid` cycles, with 40 ones on `dividend` and 20 on `divisor`. `first` is on bit 1, `last` on bit 64, and `busy` is low the cycle after.
- **Boundary operands:** `dividend_bin`=0 and `divisor_bin`=63 → `dividend` is never 1, and `divisor` has 63 ones in 64. Across the run, `randNum` covers all 64 values 0..63 exactly once.
- **Hold:** `hold` is high for 5 cycles mid-run → `valid` is low for those 5 cycles and outputs are frozen. The run ends 5 cycles later and one-counts are unchanged (40/20).
- **Ignored inputs:** change operands to 6'd1 and pulse `start` during RUN → no effect; counts stay 40/20. Back-to-back `start` in the cycle after `last` → a new run with `first` one cycle after acceptance.
- **Reset mid-run:** assert `rst` at bit 30 → outputs 0 immediately (asynchronously). After release and a new `start`, the stream is bit-identical to a fresh run with the same operands.
